gray_burst_arb: RTL and testbench

Round-robin scheduler that shares one 3-bit Gray-code step counter between NREQ requesters. Each requester asks for a burst of N counter steps. The block grants the counter to one requester at a time and drives its enable for exactly N cycles. It then returns a one-cycle completion pulse plus a wrap indication. It sits between the client logic and the Gray counter datapath and is the only agent allowed to enable that counter.

---
 rtl/gray_burst_arb_pkg.sv | 35 +++
 rtl/gray_burst_arb_gray_step_core.sv | 31 +++
 rtl/gray_burst_arb.sv | 146 ++++++++++++++
 tb/tb_gray_burst_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_burst_arb_pkg.sv
// Shared definitions for the Gray-code burst arbiter: FSM states, Gray
// sequence end points and the one-step Gray successor function.
package gray_burst_arb_pkg;

  localparam int unsigned GRAY_W = 3;

  // Start and end of the 3-bit reflected Gray sequence.
  localparam logic [GRAY_W-1:0] GRAY_FIRST = 3'b000;
  localparam logic [GRAY_W-1:0] GRAY_LAST  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Next code in 000,001,011,010,110,111,101,100,000,...
  function automatic logic [GRAY_W-1:0] gray_next(input logic [GRAY_W-1:0] code);
    logic [GRAY_W-1:0] nxt;
    nxt = GRAY_FIRST;
    case (code)
      3'b000:  nxt = 3'b001;
      3'b001:  nxt = 3'b011;
      3'b011:  nxt = 3'b010;
      3'b010:  nxt = 3'b110;
      3'b110:  nxt = 3'b111;
      3'b111:  nxt = 3'b101;
      3'b101:  nxt = 3'b100;
      3'b100:  nxt = GRAY_FIRST;
      default: nxt = GRAY_FIRST;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gray_burst_arb_gray_step_core.sv
// gray_step_core: the shared 3-bit Gray step counter.
// Ports:
//   Clk       in  rising-edge clock
//   Reset     in  asynchronous active-low reset, clears Code to 000
//   En        in  advance one Gray step on this edge
//   Code      out current Gray code (registered)
//   Step_wrap out high while the pending enabled step is 100 -> 000
module gray_step_core
  import gray_burst_arb_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  output logic [GRAY_W-1:0] Code,
  output logic              Step_wrap
);

  // Counter register; holds its value whenever En is low.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Code <= GRAY_FIRST;
    end else if (En) begin
      Code <= gray_next(Code);
    end
  end

  // Decode of the step taken at the coming edge, so the arbiter can fold it
  // into the burst's wrap result on that same edge.
  assign Step_wrap = En && (Code == GRAY_LAST);

endmodule

// File: rtl/gray_burst_arb.sv
// gray_burst_arb: round-robin owner of the shared Gray step counter. Each
// granted requester gets exactly Len[i] counter steps, then a one-cycle Done
// pulse carrying whether the counter wrapped during its burst.
// Ports:
//   Clk    in  rising-edge clock
//   Reset  in  asynchronous active-low reset
//   Req    in  [NREQ]       level request per requester
//   Len    in  [NREQ*LENW]  burst length per requester, sampled at grant
//   Grant  out [NREQ]       one-hot current owner, 0 when idle
//   Busy   out              high in RUN and DONE
//   Done   out [NREQ]       one-cycle pulse on the owner's bit at burst end
//   Wrap   out              valid with Done: counter passed 100 -> 000
//   Code   out [3]          current Gray code of the shared counter
module gray_burst_arb
  import gray_burst_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LENW = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        Req,
  input  logic [NREQ*LENW-1:0]   Len,
  output logic [NREQ-1:0]        Grant,
  output logic                   Busy,
  output logic [NREQ-1:0]        Done,
  output logic                   Wrap,
  output logic [GRAY_W-1:0]      Code
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e         state;
  logic [LENW-1:0]    rem;
  logic [IDXW-1:0]    ptr;
  logic [IDXW-1:0]    owner;
  logic               wrap_acc;

  logic               run_en;
  logic               step_wrap;
  logic               pick_valid;
  logic [IDXW-1:0]    pick_idx;
  logic [LENW-1:0]    pick_len;

  // The counter only ever moves in RUN.
  assign run_en = (state == RUN);

  gray_step_core u_core (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (run_en),
    .Code      (Code),
    .Step_wrap (step_wrap)
  );

  // Round-robin pick: scan offsets from the top down so the smallest offset
  // from ptr that has a request is the one left standing.
  always_comb begin : p_pick
    int              cand;
    logic [IDXW-1:0] cand_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= int'(NREQ)) begin
        cand = cand - int'(NREQ);
      end
      cand_idx = IDXW'(cand);
      if (Req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign pick_len = Len[32'(pick_idx) * LENW +: LENW];

  // Burst FSM with registered Grant/Busy/Done/Wrap.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      Grant    <= '0;
      Busy     <= 1'b0;
      Done     <= '0;
      Wrap     <= 1'b0;
      rem      <= '0;
      ptr      <= '0;
      owner    <= '0;
      wrap_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick_idx;
            Grant    <= ONE_HOT0 << pick_idx;
            Busy     <= 1'b1;
            rem      <= pick_len;
            wrap_acc <= 1'b0;
            if (pick_len != '0) begin
              state <= RUN;
            end else begin
              // Zero-step burst completes without touching the counter.
              state <= DONE;
              Done  <= ONE_HOT0 << pick_idx;
              Wrap  <= 1'b0;
            end
          end
        end

        RUN: begin
          rem <= rem - LENW'(1);
          if (step_wrap) begin
            wrap_acc <= 1'b1;
          end
          if (rem == LENW'(1)) begin
            // Include a wrap taken on this final step.
            state <= DONE;
            Done  <= Grant;
            Wrap  <= wrap_acc | step_wrap;
          end
        end

        DONE: begin
          state <= IDLE;
          Grant <= '0;
          Busy  <= 1'b0;
          Done  <= '0;
          Wrap  <= 1'b0;
          ptr   <= (owner == IDXW'(NREQ - 1)) ? '0 : owner + IDXW'(1);
        end

        default: begin
          state <= IDLE;
          Grant <= '0;
          Busy  <= 1'b0;
          Done  <= '0;
          Wrap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_burst_arb.sv
// Testbench for gray_burst_arb: table of single bursts, round-robin and
// mid-burst sequences; Done/Wrap/Code checked against a scoreboard fed by a
// small Gray-position model.
module tb_gray_burst_arb;
  import gray_burst_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LENW = 4;

  logic                 Clk;
  logic                 Reset;
  logic [NREQ-1:0]      Req;
  logic [NREQ*LENW-1:0] Len;
  logic [NREQ-1:0]      Grant;
  logic                 Busy;
  logic [NREQ-1:0]      Done;
  logic                 Wrap;
  logic [2:0]           Code;

  gray_burst_arb #(.NREQ(NREQ), .LENW(LENW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (Req),
    .Len   (Len),
    .Grant (Grant),
    .Busy  (Busy),
    .Done  (Done),
    .Wrap  (Wrap),
    .Code  (Code)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] done;
    logic       wrap;
    logic [2:0] code;
  } sb_t;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    int          winner;
    int          n;
  } vec_t;

  sb_t        sb_q[$];
  vec_t       vecs[6];
  logic [2:0] seq[8];
  int         pos;
  int         errors;
  int         checks;
  int         cyc;
  int         done_seen;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: advance the Gray position by n steps and queue the expected Done.
  task automatic expect_burst(input int w, input int n);
    sb_t r;
    r.done = 4'(1 << w);
    r.wrap = ((pos + n) >= 8);
    pos    = (pos + n) % 8;
    r.code = seq[pos];
    sb_q.push_back(r);
  endtask

  task automatic wait_grant(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge Clk); #1;
      if (Grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no Grant in %0d cycles, expected a Grant", limit);
    end
  endtask

  // Counts Grant-high cycles, starting from `start` already observed.
  task automatic count_grant(input int start, output int n);
    n = start;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Grant == '0) break;
      n++;
      check("busy_with_grant", 32'(Busy), 32'(1));
    end
  endtask

  // Scoreboard consumer: every Done pulse must match the oldest expectation.
  always @(negedge Clk) begin
    if (Reset) begin
      if (Done != '0) begin : pop
        sb_t r;
        done_seen++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done=%b, expected no Done", Done);
        end else begin
          r = sb_q.pop_front();
          check("done_bits", 32'(Done), 32'(r.done));
          check("done_wrap", 32'(Wrap), 32'(r.wrap));
          check("done_code", 32'(Code), 32'(r.code));
        end
      end else if (Wrap !== 1'b0) begin
        check("wrap_without_done", 32'(Wrap), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   ok;
    int   n;
    int   prev_cyc;
    int   rr_order[5];

    seq      = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    // {req, len (field i = bits 4i+3:4i), expected winner, expected steps}
    vecs[0]  = '{4'b0001, 16'h0003, 0, 3};
    vecs[1]  = '{4'b0100, 16'h0600, 2, 6};
    vecs[2]  = '{4'b0010, 16'h7707, 1, 0};
    vecs[3]  = '{4'b1001, 16'h2222, 3, 2};
    vecs[4]  = '{4'b1001, 16'h3338, 0, 8};
    vecs[5]  = '{4'b1000, 16'hF123, 3, 15};
    rr_order = '{0, 1, 2, 3, 0};
    errors = 0; checks = 0; cyc = 0; done_seen = 0; pos = 0;

    // Reset state.
    Reset = 1'b0; Req = '0; Len = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_grant", 32'(Grant), 32'(0));
    check("rst_busy",  32'(Busy),  32'(0));
    check("rst_done",  32'(Done),  32'(0));
    check("rst_wrap",  32'(Wrap),  32'(0));
    check("rst_code",  32'(Code),  32'(0));
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Reset in the middle of a Len=5 burst: dropped, no Done, counter cleared.
    Req = 4'b0010; Len = 16'h0050;
    wait_grant(10, ok);
    check("midrst_grant", 32'(Grant), 32'(4'b0010));
    repeat (2) @(posedge Clk);
    #1;
    check("midrst_code_before", 32'(Code), 32'(seq[2]));
    Reset = 1'b0; Req = '0;
    #1;
    check("midrst_grant_clr", 32'(Grant), 32'(0));
    check("midrst_busy_clr",  32'(Busy),  32'(0));
    check("midrst_code_clr",  32'(Code),  32'(0));
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    pos = 0;
    repeat (3) @(posedge Clk);
    #1;

    // Table of isolated bursts; Len is scrambled after grant on purpose.
    for (int i = 0; i < 6; i++) begin
      Req = vecs[i].req; Len = vecs[i].len;
      wait_grant(10, ok);
      if (!ok) break;
      check("tbl_grant", 32'(Grant), 32'(1 << vecs[i].winner));
      check("tbl_busy",  32'(Busy),  32'(1));
      check("tbl_code_at_grant", 32'(Code), 32'(seq[pos]));
      expect_burst(vecs[i].winner, vecs[i].n);
      Req = '0; Len = ~vecs[i].len;
      count_grant(1, n);
      check("tbl_grant_cycles", 32'(n), 32'(vecs[i].n + 1));
      check("tbl_idle_busy", 32'(Busy), 32'(0));
      check("tbl_idle_code", 32'(Code), 32'(seq[pos]));
    end

    // Round-robin with all requesters held, Len=1 each.
    Req = 4'b1111; Len = 16'h1111;
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(10, ok);
      if (!ok) break;
      check("rr_grant", 32'(Grant), 32'(1 << rr_order[g]));
      if (g > 0) check("rr_spacing", 32'(cyc - prev_cyc), 32'(3));
      prev_cyc = cyc;
      expect_burst(rr_order[g], 1);
      if (g == 4) Req = '0;
      count_grant(1, n);
      check("rr_grant_cycles", 32'(n), 32'(2));
    end

    // Req dropped in cycle 2 of a Len=4 burst: burst still completes.
    Req = 4'b0001; Len = 16'h0004;
    wait_grant(10, ok);
    check("drop_grant", 32'(Grant), 32'(4'b0001));
    expect_burst(0, 4);
    @(posedge Clk); #1;
    Req = '0;
    count_grant(2, n);
    check("drop_grant_cycles", 32'(n), 32'(5));

    repeat (4) @(posedge Clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'(0));
    check("done_count", 32'(done_seen), 32'(12));
    check("final_code", 32'(Code), 32'(seq[pos]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
